// File: rtl/ppv_port_alloc_if.sv
// Flit bus between route computation, the port allocator and the crossbar.
// The master drives the in_* flit slots; the slave returns the allocated out_* slots.
interface ppv_port_alloc_if;
    localparam int unsigned NP    = 4;
    localparam int unsigned DIR_W = 2;

    logic [NP-1:0]          in_valid;
    logic [NP*NP-1:0]       in_ppv;
    logic [NP*NP*NP-1:0]    in_pre_nppv;
    logic [NP-1:0]          out_valid;
    logic [NP*DIR_W-1:0]    out_dir;
    logic [NP*NP-1:0]       out_nppv;
    logic [NP-1:0]          out_deflect;

    modport master (
        output in_valid, in_ppv, in_pre_nppv,
        input  out_valid, out_dir, out_nppv, out_deflect
    );

    modport slave (
        input  in_valid, in_ppv, in_pre_nppv,
        output out_valid, out_dir, out_nppv, out_deflect
    );
endinterface

// File: rtl/ppv_port_alloc.sv
// Two-stage output-port allocator: S1 captures flits, allocation picks productive
// ports in round-robin slot order (deflecting when none is free), S2 registers results.
module ppv_port_alloc #(
    parameter int unsigned NUM_PORT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ppv_port_alloc_if.slave  bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] deflect_cnt
);

    localparam int unsigned DIR_W  = 2;
    localparam int unsigned PPV_W  = NUM_PORT;
    localparam int unsigned NPPV_W = NUM_PORT * NUM_PORT;
    localparam int unsigned POP_W  = 3;
    localparam int unsigned SUM_W  = CNT_W + 1;

    logic [NUM_PORT-1:0]        s1_valid_q, s1_valid_d;
    logic [NUM_PORT*PPV_W-1:0]  s1_ppv_q, s1_ppv_d;
    logic [NUM_PORT*NPPV_W-1:0] s1_nppv_q, s1_nppv_d;
    logic [DIR_W-1:0]           rr_ptr_q, rr_ptr_d;

    logic [NUM_PORT-1:0]        out_valid_q, out_valid_d;
    logic [NUM_PORT*DIR_W-1:0]  out_dir_q, out_dir_d;
    logic [NUM_PORT*PPV_W-1:0]  out_nppv_q, out_nppv_d;
    logic [NUM_PORT-1:0]        out_deflect_q, out_deflect_d;
    logic [CNT_W-1:0]           deflect_cnt_q, deflect_cnt_d;

    logic [NUM_PORT*DIR_W-1:0]  alloc_dir;
    logic [NUM_PORT-1:0]        alloc_defl;
    logic [POP_W-1:0]           defl_num;
    logic [SUM_W-1:0]           cnt_sum;

    function automatic logic [DIR_W-1:0] lowest_bit(input logic [NUM_PORT-1:0] vec);
        logic found;
        lowest_bit = '0;
        found      = 1'b0;
        for (int unsigned p = 0; p < NUM_PORT; p++) begin
            if (vec[p] && !found) begin
                lowest_bit = DIR_W'(p);
                found      = 1'b1;
            end
        end
    endfunction

    // S1 capture and pointer advance; no stall, so input is taken every cycle.
    always_comb begin
        s1_valid_d = bus.in_valid;
        s1_ppv_d   = bus.in_ppv;
        s1_nppv_d  = bus.in_pre_nppv;
        rr_ptr_d   = rr_ptr_q + DIR_W'(|s1_valid_q);
    end

    // Port allocation on S1 contents, visiting slots starting at rr_ptr.
    always_comb begin
        logic [NUM_PORT-1:0] free;
        logic [NUM_PORT-1:0] cand;
        logic [DIR_W-1:0]    slot;
        logic [DIR_W-1:0]    take;
        free       = '1;
        cand       = '0;
        slot       = '0;
        take       = '0;
        alloc_dir  = '0;
        alloc_defl = '0;
        for (int unsigned k = 0; k < NUM_PORT; k++) begin
            slot = rr_ptr_q + DIR_W'(k);
            if (s1_valid_q[slot]) begin
                cand = s1_ppv_q[slot*PPV_W +: PPV_W] & free;
                if (cand == '0) begin
                    cand             = free;
                    alloc_defl[slot] = 1'b1;
                end
                take = lowest_bit(cand);
                alloc_dir[slot*DIR_W +: DIR_W] = take;
                free[take] = 1'b0;
            end
        end
    end

    // S2 next state: results, next-hop selection and saturating deflection count.
    always_comb begin
        logic [DIR_W-1:0] d;
        d             = '0;
        out_valid_d   = s1_valid_q;
        out_dir_d     = alloc_dir;
        out_deflect_d = alloc_defl;
        out_nppv_d    = '0;
        defl_num      = '0;
        for (int unsigned i = 0; i < NUM_PORT; i++) begin
            d = alloc_dir[i*DIR_W +: DIR_W];
            if (s1_valid_q[i]) begin
                out_nppv_d[i*PPV_W +: PPV_W] = s1_nppv_q[i*NPPV_W + int'(d)*PPV_W +: PPV_W];
            end
            defl_num = defl_num + POP_W'(alloc_defl[i]);
        end
        cnt_sum = {1'b0, deflect_cnt_q} + SUM_W'(defl_num);
        if (cnt_clr) begin
            deflect_cnt_d = '0;
        end else if (cnt_sum[CNT_W]) begin
            deflect_cnt_d = '1;
        end else begin
            deflect_cnt_d = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= '0;
            s1_ppv_q      <= '0;
            s1_nppv_q     <= '0;
            rr_ptr_q      <= '0;
            out_valid_q   <= '0;
            out_dir_q     <= '0;
            out_nppv_q    <= '0;
            out_deflect_q <= '0;
            deflect_cnt_q <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_ppv_q      <= s1_ppv_d;
            s1_nppv_q     <= s1_nppv_d;
            rr_ptr_q      <= rr_ptr_d;
            out_valid_q   <= out_valid_d;
            out_dir_q     <= out_dir_d;
            out_nppv_q    <= out_nppv_d;
            out_deflect_q <= out_deflect_d;
            deflect_cnt_q <= deflect_cnt_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_dir     = out_dir_q;
    assign bus.out_nppv    = out_nppv_q;
    assign bus.out_deflect = out_deflect_q;
    assign deflect_cnt     = deflect_cnt_q;

endmodule

// File: tb/tb_ppv_port_alloc.sv
// Scoreboard bench for ppv_port_alloc: a free-port-list reference model queues the
// expected output of every cycle; a negedge monitor pops and compares.
module tb_ppv_port_alloc;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cnt_clr;
    logic [CW-1:0] deflect_cnt;

    ppv_port_alloc_if bus ();

    ppv_port_alloc #(.NUM_PORT(4), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .cnt_clr     (cnt_clr),
        .deflect_cnt (deflect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [3:0]    valid;
        logic [7:0]    dir;
        logic [15:0]   nppv;
        logic [3:0]    defl;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend;
    int   cyc = 0;
    int   rr  = 0;
    int   cnt = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.due = 0; e.valid = '0; e.dir = '0; e.nppv = '0; e.defl = '0; e.cnt = '0;
        return e;
    endfunction

    // Reference allocation: ascending list of free ports, first productive one wins.
    function automatic exp_t model_alloc(input logic [3:0] v, input logic [15:0] ppv,
                                         input logic [63:0] nppv, input int ptr);
        exp_t e;
        int   free_q[$];
        int   pick;
        int   port;
        int   s;
        e = zero_exp();
        free_q = {0, 1, 2, 3};
        e.valid = v;
        for (int k = 0; k < 4; k++) begin
            s = (ptr + k) % 4;
            if (v[s]) begin
                pick = -1;
                for (int j = 0; j < free_q.size(); j++)
                    if (pick < 0 && ppv[s*4 + free_q[j]]) pick = j;
                e.defl[s] = (pick < 0);
                if (pick < 0) pick = 0;
                port = free_q[pick];
                free_q.delete(pick);
                e.dir[s*2 +: 2]  = 2'(port);
                e.nppv[s*4 +: 4] = nppv[s*16 + port*4 +: 4];
            end
        end
        return e;
    endfunction

    // Drive one cycle; the previous cycle's allocation is finalised with this cycle's cnt_clr.
    task automatic step(input logic [3:0] v, input logic [15:0] ppv,
                        input logic [63:0] nppv, input logic clr);
        int sum;
        @(posedge clk);
        #1;
        bus.in_valid    = v;
        bus.in_ppv      = ppv;
        bus.in_pre_nppv = nppv;
        cnt_clr         = clr;
        sum = cnt + $countones(pend.defl);
        cnt = clr ? 0 : ((sum > CMAX) ? CMAX : sum);
        pend.cnt = CW'(cnt);
        pend.due = cyc + 1;
        exp_q.push_back(pend);
        pend = model_alloc(v, ppv, nppv, rr);
        rr = (rr + ((v != 4'b0) ? 1 : 0)) % 4;
    endtask

    task automatic rand_step();
        logic [15:0] p;
        for (int s = 0; s < 4; s++)
            p[s*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        step(4'($urandom_range(0, 15)), p, {$urandom(), $urandom()},
             $urandom_range(0, 15) == 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'h0);
        chk({tag, "_dir"}, 64'(bus.out_dir), 64'h0);
        chk({tag, "_nppv"}, 64'(bus.out_nppv), 64'h0);
        chk({tag, "_deflect"}, 64'(bus.out_deflect), 64'h0);
        chk({tag, "_cnt"}, 64'(deflect_cnt), 64'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                chk("due", 64'(e.due), 64'(cyc));
                chk("out_valid", 64'(bus.out_valid), 64'(e.valid));
                chk("out_dir", 64'(bus.out_dir), 64'(e.dir));
                chk("out_nppv", 64'(bus.out_nppv), 64'(e.nppv));
                chk("out_deflect", 64'(bus.out_deflect), 64'(e.defl));
                chk("deflect_cnt", 64'(deflect_cnt), 64'(e.cnt));
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        cnt_clr         = 1'b0;
        bus.in_valid    = '0;
        bus.in_ppv      = '0;
        bus.in_pre_nppv = '0;
        pend            = zero_exp();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Full conflict twice (rotation), idle hold, single productive flits, mixed PPVs.
        step(4'b1111, 16'h1111, {$urandom(), $urandom()}, 1'b0);
        step(4'b1111, 16'h1111, {$urandom(), $urandom()}, 1'b0);
        repeat (3) step(4'b0000, 16'h0, 64'h0, 1'b0);
        step(4'b0001, 16'h0004, 64'h0000_0000_0000_0300, 1'b0);
        step(4'b0001, 16'h0004, 64'h0000_0000_0000_0300, 1'b0);
        step(4'b1111, 16'h8013, {$urandom(), $urandom()}, 1'b0);
        // Counter climb to saturation, then a clear racing three deflections.
        step(4'b1111, 16'h1111, {$urandom(), $urandom()}, 1'b1);
        repeat (7) step(4'b1111, 16'h1111, {$urandom(), $urandom()}, 1'b0);
        step(4'b1111, 16'h1111, {$urandom(), $urandom()}, 1'b1);
        step(4'b0000, 16'h0, 64'h0, 1'b0);

        repeat (1500) rand_step();

        // Asynchronous reset with both stages holding flits.
        step(4'b1111, 16'h1111, {$urandom(), $urandom()}, 1'b0);
        step(4'b1011, 16'h2480, {$urandom(), $urandom()}, 1'b0);
        #1;
        rst_n           = 1'b0;
        bus.in_valid    = '0;
        bus.in_ppv      = '0;
        bus.in_pre_nppv = '0;
        exp_q.delete();
        #1;
        check_zero("async_reset");
        rst_n = 1'b1;
        pend  = zero_exp();
        rr    = 0;
        cnt   = 0;
        step(4'b0110, 16'h0330, {$urandom(), $urandom()}, 1'b0);
        repeat (300) rand_step();
        repeat (3) step(4'b0000, 16'h0, 64'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("drain", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
